// File: rtl/oam_dma_if.sv
// CPU-bus side of the sprite DMA: register write port, DMA read port and OAM write port.
// The master modport is the DMA engine; the slave modport is the CPU/bus/PPU side.
interface oam_dma_if;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        cpu_halt;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_rdata;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic        dma_done;

    modport master (
        input  reg_addr, reg_wdata, reg_we, dma_rdata,
        output cpu_halt, dma_addr, dma_rd, oam_we, oam_wdata, dma_done
    );

    modport slave (
        output reg_addr, reg_wdata, reg_we, dma_rdata,
        input  cpu_halt, dma_addr, dma_rd, oam_we, oam_wdata, dma_done
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite-OAM DMA: on a write to the DMA register, halts the CPU and copies XFER_LEN bytes
// from {page, 8'h00} to the PPU OAM data port, one GET/PUT pair per byte, GETs on even cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          XFER_LEN     = 256
) (
    input  logic       clk,
    input  logic       rst,
    oam_dma_if.master  bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT} state_t;

    state_t     state, state_nxt;
    logic       odd;
    logic [7:0] page;
    logic [8:0] idx;
    logic       trig;
    logic       last;

    assign trig = bus.reg_we && (bus.reg_addr == DMA_REG_ADDR);
    assign last = (idx == 9'(XFER_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            odd   <= 1'b0;
            page  <= 8'h00;
            idx   <= 9'd0;
        end else begin
            state <= state_nxt;
            odd   <= ~odd;
            if (state == IDLE && trig) begin
                page <= bus.reg_wdata;
                idx  <= 9'd0;
            end else if (state == PUT && !last) begin
                idx <= idx + 9'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.cpu_halt  = 1'b1;
        bus.dma_rd    = 1'b0;
        bus.dma_addr  = 16'h0000;
        bus.oam_we    = 1'b0;
        bus.oam_wdata = 8'h00;
        bus.dma_done  = 1'b0;
        case (state)
            IDLE: begin
                bus.cpu_halt = 1'b0;
                if (trig) state_nxt = HALT;
            end
            // odd==1 now means the following cycle is even, so GET can start there
            HALT:  state_nxt = odd ? GET : ALIGN;
            ALIGN: state_nxt = GET;
            GET: begin
                bus.dma_rd   = 1'b1;
                bus.dma_addr = {page, idx[7:0]};
                state_nxt    = PUT;
            end
            PUT: begin
                bus.oam_we    = 1'b1;
                bus.oam_wdata = bus.dma_rdata;
                bus.dma_done  = last;
                state_nxt     = last ? IDLE : GET;
            end
            default: begin
                bus.cpu_halt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end
endmodule
